// File: rtl/miss_mem_arbiter.sv
// Round-robin arbiter forwarding D$/I$ line misses to memory, one transaction in flight at a time.
// Optional MISS_ARB_ADDR_CHECK_EN: requests outside [MEM_BASE_ADDR, MEM_TOP_ADDR) return a bus error locally.
`ifndef THR_PER_CORE_WIDTH
`define THR_PER_CORE_WIDTH 2
`endif
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif
`ifndef MEM_BASE_ADDR
`define MEM_BASE_ADDR 32'h0000_0040
`endif
`ifndef MEM_TOP_ADDR
`define MEM_TOP_ADDR 32'h1000_0000
`endif

package miss_mem_arbiter_pkg;
    localparam int unsigned THR_W  = `THR_PER_CORE_WIDTH;
    localparam int unsigned LINE_W = `DCACHE_LINE_WIDTH;
    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              is_store;
        logic [LINE_W-1:0] data;
    } memory_request_t;
endpackage

module miss_mem_arbiter
    import miss_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT   = 256,
    parameter int unsigned TIMEOUT_WIDTH = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dc_req_valid,
    input  memory_request_t   dc_req_info,
    input  logic [THR_W-1:0]  dc_req_thread_id,
    input  logic              ic_req_valid,
    input  memory_request_t   ic_req_info,
    input  logic [THR_W-1:0]  ic_req_thread_id,
    output logic              dc_rsp_valid,
    output logic              ic_rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic [THR_W-1:0]  rsp_thread_id,
    output logic              rsp_bus_error,
    output logic              req_dropped,
    output logic              mem_req_valid,
    output memory_request_t   mem_req_info,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_error
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state;
    logic                     dc_pending;
    logic                     ic_pending;
    memory_request_t          dc_info;
    memory_request_t          ic_info;
    logic [THR_W-1:0]         dc_tid;
    logic [THR_W-1:0]         ic_tid;
    logic                     last_grant_ic;
    logic                     grant_ic;
    logic                     cur_store;
    logic [THR_W-1:0]         cur_tid;
    logic [TIMEOUT_WIDTH-1:0] timer;

    logic                     pick_ic_c;
    memory_request_t          pick_info_c;
    logic [THR_W-1:0]         pick_tid_c;
    logic                     dc_clear_c;
    logic                     ic_clear_c;
    logic                     dc_accept_c;
    logic                     ic_accept_c;
    logic                     addr_bad_c;

    // Grant selection and per-port capture/clear decisions
    always_comb begin
        pick_ic_c   = ic_pending && (!dc_pending || !last_grant_ic);
        pick_info_c = pick_ic_c ? ic_info : dc_info;
        pick_tid_c  = pick_ic_c ? ic_tid : dc_tid;
        dc_clear_c  = (state == RESP) && !grant_ic;
        ic_clear_c  = (state == RESP) && grant_ic;
        dc_accept_c = dc_req_valid && (!dc_pending || dc_clear_c);
        ic_accept_c = ic_req_valid && (!ic_pending || ic_clear_c);
    end

`ifdef MISS_ARB_ADDR_CHECK_EN
    assign addr_bad_c = (pick_info_c.addr < `MEM_BASE_ADDR) || (pick_info_c.addr >= `MEM_TOP_ADDR);
`else
    assign addr_bad_c = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            dc_pending    <= 1'b0;
            ic_pending    <= 1'b0;
            dc_info       <= '0;
            ic_info       <= '0;
            dc_tid        <= '0;
            ic_tid        <= '0;
            last_grant_ic <= 1'b0;
            grant_ic      <= 1'b0;
            cur_store     <= 1'b0;
            cur_tid       <= '0;
            timer         <= '0;
            dc_rsp_valid  <= 1'b0;
            ic_rsp_valid  <= 1'b0;
            rsp_data      <= '0;
            rsp_thread_id <= '0;
            rsp_bus_error <= 1'b0;
            req_dropped   <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_info  <= '0;
        end else begin
            req_dropped  <= (dc_req_valid && dc_pending && !dc_clear_c) ||
                            (ic_req_valid && ic_pending && !ic_clear_c);
            dc_rsp_valid <= 1'b0;
            ic_rsp_valid <= 1'b0;

            if (dc_accept_c) begin
                dc_pending <= 1'b1;
                dc_info    <= dc_req_info;
                dc_tid     <= dc_req_thread_id;
            end else if (dc_clear_c) begin
                dc_pending <= 1'b0;
            end

            if (ic_accept_c) begin
                ic_pending <= 1'b1;
                ic_info    <= ic_req_info;
                ic_tid     <= ic_req_thread_id;
            end else if (ic_clear_c) begin
                ic_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (dc_pending || ic_pending) begin
                        grant_ic  <= pick_ic_c;
                        cur_store <= pick_info_c.is_store;
                        cur_tid   <= pick_tid_c;
                        if (addr_bad_c) begin
                            // Rejected locally: memory never sees this request
                            rsp_data      <= '0;
                            rsp_bus_error <= 1'b1;
                            rsp_thread_id <= pick_tid_c;
                            dc_rsp_valid  <= !pick_ic_c;
                            ic_rsp_valid  <= pick_ic_c;
                            state         <= RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_info  <= pick_info_c;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        timer         <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_data      <= (cur_store && !mem_rsp_error) ? '0 : mem_rsp_data;
                        rsp_bus_error <= mem_rsp_error;
                        rsp_thread_id <= cur_tid;
                        dc_rsp_valid  <= !grant_ic;
                        ic_rsp_valid  <= grant_ic;
                        state         <= RESP;
                    end else if (timer == TIMEOUT_WIDTH'(MEM_TIMEOUT - 1)) begin
                        rsp_data      <= '0;
                        rsp_bus_error <= 1'b1;
                        rsp_thread_id <= cur_tid;
                        dc_rsp_valid  <= !grant_ic;
                        ic_rsp_valid  <= grant_ic;
                        state         <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    last_grant_ic <= grant_ic;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_miss_mem_arbiter.sv
// Directed self-checking bench for miss_mem_arbiter (MEM_TIMEOUT=16); honours MISS_ARB_ADDR_CHECK_EN.
`ifndef MEM_TOP_ADDR
`define MEM_TOP_ADDR 32'h1000_0000
`endif

module tb_miss_mem_arbiter;
    import miss_mem_arbiter_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              dc_req_valid;
    memory_request_t   dc_req_info;
    logic [THR_W-1:0]  dc_req_thread_id;
    logic              ic_req_valid;
    memory_request_t   ic_req_info;
    logic [THR_W-1:0]  ic_req_thread_id;
    logic              dc_rsp_valid;
    logic              ic_rsp_valid;
    logic [LINE_W-1:0] rsp_data;
    logic [THR_W-1:0]  rsp_thread_id;
    logic              rsp_bus_error;
    logic              req_dropped;
    logic              mem_req_valid;
    memory_request_t   mem_req_info;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              mem_rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    miss_mem_arbiter #(.MEM_TIMEOUT(16), .TIMEOUT_WIDTH(5)) dut (
        .clock(clock), .reset(reset),
        .dc_req_valid(dc_req_valid), .dc_req_info(dc_req_info), .dc_req_thread_id(dc_req_thread_id),
        .ic_req_valid(ic_req_valid), .ic_req_info(ic_req_info), .ic_req_thread_id(ic_req_thread_id),
        .dc_rsp_valid(dc_rsp_valid), .ic_rsp_valid(ic_rsp_valid), .rsp_data(rsp_data),
        .rsp_thread_id(rsp_thread_id), .rsp_bus_error(rsp_bus_error), .req_dropped(req_dropped),
        .mem_req_valid(mem_req_valid), .mem_req_info(mem_req_info), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic memory_request_t mk_req(input logic [31:0] a, input logic st,
                                               input logic [LINE_W-1:0] d);
        memory_request_t r;
        r.addr     = a;
        r.is_store = st;
        r.data     = d;
        return r;
    endfunction

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_issue"}, 256'(mem_req_valid), 256'(1));
    endtask

    // Memory model: accept the request, then answer after one WAIT cycle
    task automatic mem_serve(input string tag, input logic [31:0] addr,
                             input logic [LINE_W-1:0] data, input logic err);
        wait_issue(tag);
        check_eq({tag, "_addr"}, 256'(mem_req_info.addr), 256'(addr));
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_error = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_error = 1'b0;
    endtask

    task automatic check_no_rsp(input string tag);
        check_eq({tag, "_dc_rsp"}, 256'(dc_rsp_valid), 256'(0));
        check_eq({tag, "_ic_rsp"}, 256'(ic_rsp_valid), 256'(0));
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a5;
        int                k;
        int                pulses;
        int                issued;

        pat_a5 = {(LINE_W/8){8'hA5}};
        reset = 1'b1;
        dc_req_valid = 1'b0; dc_req_info = '0; dc_req_thread_id = '0;
        ic_req_valid = 1'b0; ic_req_info = '0; ic_req_thread_id = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_error = 1'b0;
        tick();
        tick();
        check_no_rsp("reset");
        check_eq("reset_mem_req_valid", 256'(mem_req_valid), 256'(0));
        check_eq("reset_dropped", 256'(req_dropped), 256'(0));
        check_eq("reset_err", 256'(rsp_bus_error), 256'(0));
        reset = 1'b0;

        // D$ load, issue latency and response 5 cycles after acceptance
        dc_req_valid = 1'b1; dc_req_info = mk_req(32'h100, 1'b0, '0); dc_req_thread_id = THR_W'(1);
        tick();
        dc_req_valid = 1'b0;
        check_eq("t1_issue_early", 256'(mem_req_valid), 256'(0));
        tick();
        check_eq("t1_issue", 256'(mem_req_valid), 256'(1));
        check_eq("t1_addr", 256'(mem_req_info.addr), 256'(32'h100));
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq("t1_req_low", 256'(mem_req_valid), 256'(0));
        repeat (4) tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("t1_dc_rsp", 256'(dc_rsp_valid), 256'(1));
        check_eq("t1_ic_rsp", 256'(ic_rsp_valid), 256'(0));
        check_eq("t1_tid", 256'(rsp_thread_id), 256'(1));
        check_eq("t1_err", 256'(rsp_bus_error), 256'(0));
        check_eq("t1_data", 256'(rsp_data), 256'(pat_a5));
        tick();
        check_no_rsp("t1_after");

        // Simultaneous requests: I$ first, then D$
        dc_req_valid = 1'b1; dc_req_info = mk_req(32'h200, 1'b0, '0); dc_req_thread_id = THR_W'(2);
        ic_req_valid = 1'b1; ic_req_info = mk_req(32'h300, 1'b0, '0); ic_req_thread_id = THR_W'(3);
        tick();
        dc_req_valid = 1'b0; ic_req_valid = 1'b0;
        mem_serve("t2_ic", 32'h300, LINE_W'(128'h1111), 1'b0);
        check_eq("t2_ic_rsp", 256'(ic_rsp_valid), 256'(1));
        check_eq("t2_ic_dc_rsp", 256'(dc_rsp_valid), 256'(0));
        check_eq("t2_ic_tid", 256'(rsp_thread_id), 256'(3));
        tick();
        check_no_rsp("t2_gap");
        mem_serve("t2_dc", 32'h200, LINE_W'(128'h2222), 1'b0);
        check_eq("t2_dc_rsp", 256'(dc_rsp_valid), 256'(1));
        check_eq("t2_dc_ic_rsp", 256'(ic_rsp_valid), 256'(0));
        check_eq("t2_dc_tid", 256'(rsp_thread_id), 256'(2));
        check_eq("t2_dc_data", 256'(rsp_data), 256'(128'h2222));
        tick();
        check_no_rsp("t2_after");

        // Second D$ request while pending is dropped
        dc_req_valid = 1'b1; dc_req_info = mk_req(32'h400, 1'b0, '0); dc_req_thread_id = THR_W'(0);
        tick();
        dc_req_info = mk_req(32'h500, 1'b0, '0);
        tick();
        dc_req_valid = 1'b0;
        check_eq("t3_dropped", 256'(req_dropped), 256'(1));
        check_eq("t3_first_addr", 256'(mem_req_info.addr), 256'(32'h400));
        tick();
        check_eq("t3_dropped_pulse", 256'(req_dropped), 256'(0));
        mem_serve("t3", 32'h400, LINE_W'(128'h3333), 1'b0);
        check_eq("t3_dc_rsp", 256'(dc_rsp_valid), 256'(1));
        issued = 0;
        repeat (4) begin
            tick();
            issued += int'(mem_req_valid);
        end
        check_eq("t3_no_second_issue", 256'(issued), 256'(0));

        // I$ timeout after 16 WAIT cycles; late response ignored
        ic_req_valid = 1'b1; ic_req_info = mk_req(32'h600, 1'b0, '0); ic_req_thread_id = THR_W'(1);
        tick();
        ic_req_valid = 1'b0;
        wait_issue("t4");
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        k = 0;
        while (!dc_rsp_valid && !ic_rsp_valid && k < 40) begin
            tick();
            k++;
        end
        check_eq("t4_latency", 256'(k), 256'(16));
        check_eq("t4_ic_rsp", 256'(ic_rsp_valid), 256'(1));
        check_eq("t4_err", 256'(rsp_bus_error), 256'(1));
        check_eq("t4_data", 256'(rsp_data), 256'(0));
        check_eq("t4_tid", 256'(rsp_thread_id), 256'(1));
        mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        tick();
        mem_rsp_valid = 1'b0;
        pulses = 0;
        repeat (5) begin
            pulses += int'(dc_rsp_valid) + int'(ic_rsp_valid);
            tick();
        end
        check_eq("t4_late_rsp", 256'(pulses), 256'(0));

        // Round-robin after an I$ grant favours D$; store returns zero data
        dc_req_valid = 1'b1; dc_req_info = mk_req(32'h700, 1'b1, LINE_W'(128'h77)); dc_req_thread_id = THR_W'(0);
        ic_req_valid = 1'b1; ic_req_info = mk_req(32'h900, 1'b0, '0); ic_req_thread_id = THR_W'(2);
        tick();
        dc_req_valid = 1'b0; ic_req_valid = 1'b0;
        mem_serve("rr_dc", 32'h700, LINE_W'(128'hBEEF), 1'b0);
        check_eq("rr_dc_rsp", 256'(dc_rsp_valid), 256'(1));
        check_eq("rr_store_data", 256'(rsp_data), 256'(0));
        check_eq("rr_store_err", 256'(rsp_bus_error), 256'(0));
        tick();
        mem_serve("rr_ic", 32'h900, LINE_W'(128'h1234), 1'b0);
        check_eq("rr_ic_rsp", 256'(ic_rsp_valid), 256'(1));
        check_eq("rr_ic_data", 256'(rsp_data), 256'(128'h1234));
        check_eq("rr_ic_tid", 256'(rsp_thread_id), 256'(2));
        tick();

        // Reset while waiting on memory
        dc_req_valid = 1'b1; dc_req_info = mk_req(32'h800, 1'b0, '0); dc_req_thread_id = THR_W'(3);
        tick();
        dc_req_valid = 1'b0;
        wait_issue("t5");
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_no_rsp("t5_reset");
        check_eq("t5_mem_req", 256'(mem_req_valid), 256'(0));
        check_eq("t5_data", 256'(rsp_data), 256'(0));
        check_eq("t5_tid", 256'(rsp_thread_id), 256'(0));
        mem_rsp_valid = 1'b1; mem_rsp_data = pat_a5;
        tick();
        mem_rsp_valid = 1'b0;
        pulses = 0;
        issued = 0;
        repeat (6) begin
            pulses += int'(dc_rsp_valid) + int'(ic_rsp_valid);
            issued += int'(mem_req_valid);
            tick();
        end
        check_eq("t5_no_rsp", 256'(pulses), 256'(0));
        check_eq("t5_no_issue", 256'(issued), 256'(0));

`ifdef MISS_ARB_ADDR_CHECK_EN
        // Address at the top bound is rejected without a memory request
        dc_req_valid = 1'b1; dc_req_info = mk_req(`MEM_TOP_ADDR, 1'b0, '0); dc_req_thread_id = THR_W'(1);
        tick();
        dc_req_valid = 1'b0;
        issued = 0;
        k = 0;
        while (!dc_rsp_valid && k < 10) begin
            issued += int'(mem_req_valid);
            tick();
            k++;
        end
        check_eq("t6_no_issue", 256'(issued), 256'(0));
        check_eq("t6_dc_rsp", 256'(dc_rsp_valid), 256'(1));
        check_eq("t6_err", 256'(rsp_bus_error), 256'(1));
        check_eq("t6_data", 256'(rsp_data), 256'(0));
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
